// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the EX/MEM pipeline register and a single-port RAM.
// Issues one bus request per access, stalls the pipeline until ack or timeout.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic        mem_sign_ext_flag,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic        ram_ack,
  input  logic [31:0] ram_read_data,
  output logic [31:0] read_data,
  output logic        bus_error,
  output logic        stall_request
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        ram_en_q, ram_en_d;
  logic [3:0]  ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        sext_q, sext_d;
  logic        is_write_q, is_write_d;
  logic [31:0] read_data_q, read_data_d;
  logic        bus_error_q, bus_error_d;
  logic        stall_c;

  // Low address bits only matter through the byte enables.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [3:0]  sel,
                                          input logic        sx);
    logic [31:0] r;
    r = w;
    case (sel)
      4'b0001: r = {{24{sx & w[7]}},  w[7:0]};
      4'b0010: r = {{24{sx & w[15]}}, w[15:8]};
      4'b0100: r = {{24{sx & w[23]}}, w[23:16]};
      4'b1000: r = {{24{sx & w[31]}}, w[31:24]};
      4'b0011: r = {{16{sx & w[15]}}, w[15:0]};
      4'b1100: r = {{16{sx & w[31]}}, w[31:16]};
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      sel_q       <= '0;
      sext_q      <= 1'b0;
      is_write_q  <= 1'b0;
      read_data_q <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      sel_q       <= sel_d;
      sext_q      <= sext_d;
      is_write_q  <= is_write_d;
      read_data_q <= read_data_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    sel_d       = sel_q;
    sext_d      = sext_q;
    is_write_d  = is_write_q;
    read_data_d = read_data_q;
    bus_error_d = bus_error_q;
    stall_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_read_flag || mem_write_flag) begin
          stall_c     = 1'b1;
          state_d     = BUSY;
          wait_cnt_d  = '0;
          ram_en_d    = 1'b1;
          ram_addr_d  = {mem_addr[31:2], 2'b00};
          ram_wdata_d = mem_write_data;
          ram_we_d    = mem_write_flag ? mem_sel : 4'b0000;
          sel_d       = mem_sel;
          sext_d      = mem_sign_ext_flag;
          is_write_d  = mem_write_flag;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (ram_ack) begin
          state_d  = DONE;
          ram_en_d = 1'b0;
          ram_we_d = 4'b0000;
          if (!is_write_q) begin
            read_data_d = extract(ram_read_data, sel_q, sext_q);
          end
        end else if (wait_cnt_q == TIMEOUT_C) begin
          state_d     = DONE;
          ram_en_d    = 1'b0;
          ram_we_d    = 4'b0000;
          read_data_d = '0;
          bus_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      // EX/MEM still holds the finished instruction here, so its flags are ignored.
      DONE: begin
        state_d     = IDLE;
        bus_error_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_request  = rst & stall_c;
  assign ram_en         = ram_en_q;
  assign ram_write_en   = ram_we_q;
  assign ram_addr       = ram_addr_q;
  assign ram_write_data = ram_wdata_q;
  assign read_data      = read_data_q;
  assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT=4; inputs driven 1 time unit
// after the rising edge, outputs checked before the following edge.
module tb_mem_access_ctrl;

  logic        clk, rst;
  logic        rd, wr, sx, ack;
  logic [3:0]  sel;
  logic [31:0] addr, wdata, rdata;
  logic        ram_en, bus_error, stall;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata, read_data;

  int n_pass  = 0;
  int n_total = 0;
  int txn     = 0;
  int txn_base;
  logic prev_en = 1'b0;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_flag     (rd),
    .mem_write_flag    (wr),
    .mem_sign_ext_flag (sx),
    .mem_sel           (sel),
    .mem_addr          (addr),
    .mem_write_data    (wdata),
    .ram_en            (ram_en),
    .ram_write_en      (ram_we),
    .ram_addr          (ram_addr),
    .ram_write_data    (ram_wdata),
    .ram_ack           (ack),
    .ram_read_data     (rdata),
    .read_data         (read_data),
    .bus_error         (bus_error),
    .stall_request     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts bus transactions as rising edges of ram_en.
  always @(negedge clk) begin
    if (ram_en && !prev_en) txn <= txn + 1;
    prev_en <= ram_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle-ack load issued from IDLE; returns with the DUT in DONE.
  task automatic load_imm(input logic [31:0] a, input logic [3:0] s,
                          input logic x, input logic [31:0] d);
    rd = 1'b1; wr = 1'b0; addr = a; sel = s; sx = x;
    step();
    ack = 1'b1; rdata = d;
    step();
    ack = 1'b0; rd = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rd = 1'b1; wr = 1'b0; sx = 1'b0; ack = 1'b0;
    sel = 4'h0; addr = '0; wdata = '0; rdata = '0;
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_bus_error", bus_error, 0);
    rd = 1'b0;
    @(negedge clk) rst = 1'b1;
    step();

    // Word load, ack in the second BUSY cycle
    rd = 1'b1; addr = 32'h0000_1003; sel = 4'b1111;
    #1;
    chk("wl_stall_req", stall, 1);
    step();
    chk("wl_ram_en", ram_en, 1);
    chk("wl_ram_addr", ram_addr, 32'h0000_1000);
    chk("wl_we", ram_we, 4'b0000);
    chk("wl_stall_busy1", stall, 1);
    step();
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    chk("wl_stall_busy2", stall, 1);
    chk("wl_ram_en_busy2", ram_en, 1);
    step();
    ack = 1'b0;
    chk("wl_done_stall", stall, 0);
    chk("wl_done_data", read_data, 32'hDEAD_BEEF);
    chk("wl_done_en", ram_en, 0);
    step();
    rd = 1'b0;
    chk("wl_idle_hold", read_data, 32'hDEAD_BEEF);
    chk("wl_idle_err", bus_error, 0);

    // Byte loads, signed and unsigned
    load_imm(32'h0000_2002, 4'b0100, 1'b1, 32'h0080_FF00);
    chk("sb_signed", read_data, 32'hFFFF_FF80);
    chk("sb_done_stall", stall, 0);
    step();
    load_imm(32'h0000_2002, 4'b0100, 1'b0, 32'h0080_FF00);
    chk("sb_unsigned", read_data, 32'h0000_0080);
    step();

    // Other extraction patterns
    load_imm(32'h0000_2100, 4'b0011, 1'b1, 32'h1234_8001);
    chk("lh_lo_signed", read_data, 32'hFFFF_8001);
    step();
    load_imm(32'h0000_2102, 4'b1100, 1'b0, 32'hF00D_1234);
    chk("lh_hi_unsigned", read_data, 32'h0000_F00D);
    step();
    load_imm(32'h0000_2104, 4'b0001, 1'b1, 32'hFFFF_FF7F);
    chk("lb0_pos", read_data, 32'h0000_007F);
    step();
    load_imm(32'h0000_2107, 4'b1000, 1'b1, 32'h9A00_0000);
    chk("lb3_signed", read_data, 32'hFFFF_FF9A);
    step();
    load_imm(32'h0000_2108, 4'b0010, 1'b0, 32'h0000_C300);
    chk("lb1_unsigned", read_data, 32'h0000_00C3);
    step();
    load_imm(32'h0000_210C, 4'b0101, 1'b1, 32'h8080_8080);
    chk("odd_sel_raw", read_data, 32'h8080_8080);
    step();

    // Halfword store, immediate ack
    wr = 1'b1; sel = 4'b1100; addr = 32'h0000_3006; wdata = 32'hABCD_0000;
    step();
    chk("st_we", ram_we, 4'b1100);
    chk("st_addr", ram_addr, 32'h0000_3004);
    chk("st_wdata", ram_wdata, 32'hABCD_0000);
    ack = 1'b1; rdata = 32'h1111_1111;
    step();
    ack = 1'b0; wr = 1'b0;
    chk("st_we_cleared", ram_we, 4'b0000);
    chk("st_read_hold", read_data, 32'h8080_8080);
    step();

    // Both flags: write wins
    rd = 1'b1; wr = 1'b1; sel = 4'b1111; addr = 32'h0000_3100; wdata = 32'h55AA_55AA;
    step();
    chk("both_we", ram_we, 4'b1111);
    ack = 1'b1; rdata = 32'h1234_5678;
    step();
    ack = 1'b0; rd = 1'b0; wr = 1'b0;
    chk("both_no_load", read_data, 32'h8080_8080);
    step();

    // Ack while idle is ignored
    ack = 1'b1; rdata = 32'hCAFE_F00D;
    step();
    ack = 1'b0;
    chk("idle_ack_en", ram_en, 0);
    chk("idle_ack_data", read_data, 32'h8080_8080);
    chk("idle_ack_state", stall, 0);

    // Reset asserted in the second BUSY cycle
    rd = 1'b1; sel = 4'b1111; addr = 32'h0000_4000;
    step();
    step();
    chk("mr_pre_en", ram_en, 1);
    #1 rst = 1'b0;
    #1;
    chk("mr_ram_en", ram_en, 0);
    chk("mr_stall", stall, 0);
    chk("mr_addr", ram_addr, 0);
    chk("mr_read_data", read_data, 0);
    rd = 1'b0;
    @(negedge clk) rst = 1'b1;
    step();
    load_imm(32'h0000_4008, 4'b1111, 1'b0, 32'h0BAD_F00D);
    chk("mr_after_load", read_data, 32'h0BAD_F00D);
    step();

    // Timeout with no ack: 5 BUSY cycles then one error cycle
    rd = 1'b1; sel = 4'b1111; addr = 32'h0000_5000;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("to_busy%0d_en", i), ram_en, 1);
      chk($sformatf("to_busy%0d_err", i), bus_error, 0);
      step();
    end
    chk("to_bus_error", bus_error, 1);
    chk("to_read_zero", read_data, 0);
    chk("to_en_cleared", ram_en, 0);
    chk("to_done_stall", stall, 0);
    step();
    rd = 1'b0;
    chk("to_err_cleared", bus_error, 0);
    chk("to_idle_en", ram_en, 0);

    // Back-to-back read then write with flags held through DONE
    txn_base = txn;
    rd = 1'b1; sel = 4'b1111; addr = 32'h0000_6000;
    step();
    ack = 1'b1; rdata = 32'h0102_0304;
    step();
    ack = 1'b0;
    rd = 1'b0; wr = 1'b1; sel = 4'b0011; addr = 32'h0000_6010; wdata = 32'h0000_BEEF;
    chk("b2b_done_stall", stall, 0);
    chk("b2b_read", read_data, 32'h0102_0304);
    step();
    chk("b2b_idle_stall", stall, 1);
    step();
    chk("b2b_we", ram_we, 4'b0011);
    chk("b2b_addr", ram_addr, 32'h0000_6010);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("b2b_done_en", ram_en, 0);
    step();
    wr = 1'b0;
    step();
    step();
    chk("b2b_txn_count", txn - txn_base, 2);
    chk("b2b_read_hold", read_data, 32'h0102_0304);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum BUSY cycles to wait for ram_ack; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 mem_read_flag / mem_write_flag / mem_sign_ext_flag  input  1 each  access controls from the EX/MEM pipeline register.
REQ-005 mem_sel  input  4  byte enables from EX/MEM; bit i selects byte lane i.
REQ-006 mem_addr  input  32  access address (EX result); mem_write_data  input  32  store data, already lane-aligned.
REQ-007 ram_en  output  1  bus request; ram_write_en  output  4  byte write strobes, all zero for reads.
REQ-008 ram_addr  output  32  word-aligned address; ram_write_data  output  32  store data.
REQ-009 ram_ack  input  1  one-cycle completion from memory; ram_read_data  input  32  valid when ram_ack is high.
REQ-010 read_data  output  32  aligned, extended load result; bus_error  output  1  timeout indication.
REQ-011 stall_request  output  1  freezes EX/MEM and earlier stages while high.

Function
REQ-012 FSM states SHALL be IDLE, BUSY and DONE, encoded in 2 bits; IDLE is the reset state.
REQ-013 IDLE with mem_read_flag or mem_write_flag high: stall_request SHALL be high combinationally in the same cycle, and the FSM SHALL enter BUSY at the next edge.
REQ-014 On the IDLE->BUSY edge the block SHALL register the bus outputs:
- ram_en=1
- ram_addr={mem_addr[31:2],2'b00}
- ram_write_data=mem_write_data
- ram_write_en=mem_sel for writes, 4'b0000 for reads
- internal copies of mem_sel and mem_sign_ext_flag
REQ-015 If both flags are high, the access SHALL be a write; no read occurs.
REQ-016 BUSY: stall_request=1, and the bus outputs SHALL stay constant until exit.
REQ-017 BUSY: an 8-bit wait counter SHALL start at 0 on entry and increment each cycle without ram_ack.
REQ-018 BUSY with ram_ack=1: the FSM SHALL enter DONE at the next edge, ram_en and ram_write_en SHALL clear on that edge, and for reads read_data SHALL load the extracted value (REQ-021).
REQ-019 BUSY with the counter equal to TIMEOUT and ram_ack=0: the FSM SHALL enter DONE, clear ram_en/ram_write_en, load read_data=0 and set bus_error=1.
REQ-020 DONE: stall_request=0 and the access flags SHALL be ignored, because EX/MEM still holds the completed instruction. The next edge SHALL go to IDLE and clear bus_error. read_data SHALL hold its value until the next load completes.
REQ-021 Load extraction SHALL use the registered sel.
- One-hot sel (0001/0010/0100/1000): the corresponding byte.
- 0011: bits[15:0]; 1100: bits[31:16].
- 1111: the full word.
- Byte/half results: sign-extended to 32 bits when the sign-ext flag is set, otherwise zero-extended.
- Any other sel pattern: the raw word, unextended.
REQ-022 ram_ack received in IDLE or DONE SHALL be ignored.
REQ-023 Write completion SHALL leave read_data unchanged.
REQ-024 A new access SHALL start at the earliest in the cycle after DONE, so minimum latency is 3 cycles: IDLE-request, BUSY with ack, DONE.

Reset
REQ-025 rst low SHALL immediately force IDLE and clear the wait counter, ram_en, ram_write_en, ram_addr, ram_write_data, read_data and bus_error to 0, including mid-BUSY.
REQ-026 stall_request SHALL be 0 while rst is low; the first access is accepted in the first IDLE cycle after release.

Verification
REQ-027 Word load: read_flag=1, addr=0x1003, sel=1111, ack after 2 BUSY cycles with data 0xDEADBEEF -> ram_addr=0x1000, write_en=0000, stall high for 3 cycles (request cycle + 2 BUSY), read_data=0xDEADBEEF in DONE.
REQ-028 Signed byte: sel=0100, sign_ext=1, data 0x0080FF00 -> read_data=0xFFFFFF80; same access with sign_ext=0 -> 0x00000080.
REQ-029 Halfword store: write_flag=1, sel=1100, data 0xABCD0000, immediate ack -> ram_write_en=1100 for exactly 1 cycle, read_data unchanged.
REQ-030 Timeout: TIMEOUT=4, read with no ack -> ram_en high for 5 BUSY cycles, then bus_error=1 and read_data=0 for one cycle, then IDLE.
REQ-031 Reset mid-BUSY: rst low in the 2nd BUSY cycle -> ram_en=0 and stall_request=0 without waiting for clk; a following read completes normally.
REQ-032 Back-to-back: read followed by write, flags held through DONE -> exactly two bus transactions, no duplicate access during DONE.
